dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised, clocked data memory with an integrated RV32 load/store formatter. It replaces the four-port, level-strobed byte RAM with a single request/response port that accepts byte-granular RV32 loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW). It also performs sign/zero extension and flags misaligned and out-of-range accesses. It sits between the MEM stage of the core and on-chip data storage, with one transaction outstanding.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; power of two, at least 4.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  single clock; everything updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  response accepted when rsp_valid and rsp_ready are both high.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal funct3.

## Operation
- Storage is DEPTH_WORDS x 32 bits, organised as 4 byte lanes. Word index = req_addr[2 +: log2(DEPTH_WORDS)]; byte offset = req_addr[1:0].
- The FSM has two states: IDLE and RESP.
  - IDLE: req_ready = 1. On accept, go to RESP.
  - RESP: rsp_valid = 1. On rsp_ready with no new request, go to IDLE. On rsp_ready together with a new accepted request, stay in RESP and load the new response (back-to-back).
- req_ready = (state == IDLE) || rsp_ready.
- Error checks:
  - misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0;
  - out-of-range: any addr bit at or above 2 + log2(DEPTH_WORDS) is set;
  - illegal funct3: any code not listed in the Interface.
- On error: no memory write, rsp_err = 1, rsp_rdata = 0.
- Store byte enables:
  - SB: 1 << off.
  - SH: 0011 << off. off is 0 or 2.
  - SW: 1111.
  - Write data is replicated across lanes: B as {4{b}}, H as {2{h}}.
- Load extraction: select the lane(s) by offset. B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- Store response: rsp_valid with rsp_err as computed and rsp_rdata = 0.
- Storage contents are not reset; unwritten words read as X in simulation.

## Timing
- Store commit: the memory write happens on the accept edge. A load accepted on the next cycle to the same address returns the new data.
- Load latency: read data is captured into the rsp_rdata register on the accept edge. rsp_valid is therefore high the cycle after accept, which is 1-cycle latency.
- Response outputs stay stable while rsp_valid = 1 and rsp_ready = 0.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0. req_ready is 1 from the first cycle after reset.
- Reset while in RESP: the pending response is dropped with no rsp_valid afterwards.
- Store presented in the same cycle as rst: it is not written, and req_ready is treated as 0 in that cycle.
- Address wrap-around is not performed. Out-of-range addresses are errors and never alias onto low words.
- Throughput: one transaction per cycle when rsp_ready is held high.

## Structure
- Package dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum (IDLE, RESP);
  - the function computing byte enables from funct3 and offset.
- Sub-module dmem_bank: DEPTH_WORDS x 32 synchronous-write, 4-lane byte-enable array with one read port and one write port. It contains no formatting logic. dmem_lsu contains the FSM, the checks and the extension logic.

## Test plan
- Word store and byte reloads:
  - SW 0x8000_00FF to addr 0x10, then LW 0x10 -> rsp_rdata 0x8000_00FF, err 0.
  - LB 0x10 -> 0xFFFF_FFFF.
  - LBU 0x13 -> 0x0000_0080.
- Sub-word stores after SW 0 to 0x20:
  - SB 0xA5 to 0x22, then SH 0x1234 to 0x20, then LW 0x20 -> 0x00A5_1234.
  - LH 0x22 -> 0x0000_00A5.
  - LHU 0x20 -> 0x0000_1234.
- Errors (DEPTH_WORDS = 64), each -> rsp_err 1 and rsp_rdata 0:
  - LH 0x21;
  - SW 0x22, after which a following LW 0x20 shows the contents unchanged;
  - LW 0x100;
  - funct3 = 011.
- Back-to-back with rsp_ready held 1: SW 0x11223344 to 0x04 and LW 0x04 on consecutive cycles -> both accepted with no stall, and the load returns 0x11223344.
- Backpressure: hold rsp_ready 0 for 3 cycles after an LW -> req_ready 0, rsp_valid and rsp_rdata stable; release -> exactly one response.
- Reset:
  - assert rst in RESP -> rsp_valid 0 the next cycle and no stale response afterwards;
  - SW with rst high -> memory word unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32 load/store data memory: width codes,
// FSM state encoding and the store byte-enable helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Lane enables for a store; unknown width codes enable nothing.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3,
                                         input logic [1:0] off);
    case (funct3)
      F3_B:    byte_en = 4'b0001 << off;
      F3_H:    byte_en = 4'b0011 << off;
      F3_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH_WORDS x 32 storage in four byte lanes: synchronous byte-enabled write,
// combinational read. Contents are not reset.
module dmem_bank #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[widx][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with integrated RV32 load/store formatting, one transaction
// outstanding, single request/response handshake port.
//
//   state | meaning
//   IDLE  | no response pending; request port open
//   RESP  | response held on rsp_*; a new request is taken only with rsp_ready
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic             accept;
  logic             misaligned, illegal, out_of_range, err;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word, wr_data, load_ext;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             mem_we;

  assign off = req_addr[1:0];
  assign idx = req_addr[2 +: IDX_W];

  // A request coinciding with reset is never accepted, so it cannot write.
  assign req_ready = ~rst & ((state_q == IDLE) | rsp_ready);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state_q == RESP);

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = |req_addr[1:0];
      default:     illegal    = 1'b1;
    endcase
  end

  // Any address bit above the word index is an error; no aliasing.
  assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;
  assign err          = misaligned | illegal | out_of_range;

  always_comb begin
    wr_data = req_wdata;
    case (req_funct3)
      F3_B:    wr_data = {4{req_wdata[7:0]}};
      F3_H:    wr_data = {2{req_wdata[15:0]}};
      default: wr_data = req_wdata;
    endcase
  end

  assign mem_we = accept & req_we & ~err;

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk  (clk),
    .we   (mem_we),
    .be   (byte_en(req_funct3, off)),
    .widx (idx),
    .wdata(wr_data),
    .ridx (idx),
    .rdata(rd_word)
  );

  always_comb begin
    case (off)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext = {24'd0, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_ext = {16'd0, half_sel};
      F3_W:    load_ext = rd_word;
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: if (rsp_ready) state_d = accept ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_err   <= err;
        rsp_rdata <= (req_we | err) ? 32'd0 : load_ext;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: stores/reloads, sub-word formatting, error
// cases, back-to-back, backpressure and reset behaviour.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction with rsp_ready held high; returns the response.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rdata, output logic err);
    int n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  task automatic expect_rsp(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] r;
    logic        e;
    txn(tag, we, f3, addr, wd, r, e);
    chk({tag, "_rdata"}, r, exp_rd);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Word store and byte reloads
    expect_rsp("sw_10",  1'b1, 3'b010, 32'h10, 32'h8000_00FF, 32'h0, 1'b0);
    expect_rsp("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_00FF, 1'b0);
    expect_rsp("lb_10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0);
    expect_rsp("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0);

    // Sub-word stores
    expect_rsp("sw_20",  1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
    expect_rsp("sb_22",  1'b1, 3'b000, 32'h22, 32'hFFFF_FFA5, 32'h0, 1'b0);
    expect_rsp("sh_20",  1'b1, 3'b001, 32'h20, 32'hABCD_1234, 32'h0, 1'b0);
    expect_rsp("lw_20",  1'b0, 3'b010, 32'h20, 32'h0, 32'h00A5_1234, 1'b0);
    expect_rsp("lh_22",  1'b0, 3'b001, 32'h22, 32'h0, 32'h0000_00A5, 1'b0);
    expect_rsp("lhu_20", 1'b0, 3'b101, 32'h20, 32'h0, 32'h0000_1234, 1'b0);

    // Errors
    expect_rsp("lh_21_mis",  1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1);
    expect_rsp("sw_22_mis",  1'b1, 3'b010, 32'h22, 32'hDEAD_BEEF, 32'h0, 1'b1);
    expect_rsp("lw_20_kept", 1'b0, 3'b010, 32'h20, 32'h0, 32'h00A5_1234, 1'b0);
    expect_rsp("lw_100_oor", 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1);
    expect_rsp("f3_011",     1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
    expect_rsp("sw_120_oor", 1'b1, 3'b010, 32'h120, 32'hDEAD_BEEF, 32'h0, 1'b1);
    expect_rsp("lw_20_noalias", 1'b0, 3'b010, 32'h20, 32'h0, 32'h00A5_1234, 1'b0);

    // Back-to-back: store then load on consecutive cycles
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h04; req_wdata = 32'h1122_3344;
    chk("b2b_st_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b_st_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_st_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    req_we = 1'b0; req_wdata = 32'h0;
    chk("b2b_ld_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_ld_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_ld_rdata", rsp_rdata, 32'h1122_3344);
    @(posedge clk); #1;
    chk("b2b_drained", 32'(rsp_valid), 32'd0);

    // Backpressure
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h04;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1122_3344);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_single_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_no_extra", 32'(rsp_valid), 32'd0);

    // Reset while a response is pending
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rr_pending", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rr_dropped", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rr_no_stale", 32'(rsp_valid), 32'd0);

    // Store presented together with reset must not write
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    chk("sw_rst_no_rsp", 32'(rsp_valid), 32'd0);
    expect_rsp("sw_rst_unchanged", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_00FF, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
